// File: rtl/vga_pkg.sv
// Shared VGA geometry, coordinate/colour widths and the pixel record.
// Also imported by the scan-out timing generator.
package vga_pkg;

    localparam int H_SIZE   = 640;
    localparam int V_SIZE   = 480;
    localparam int X_W      = 10;
    localparam int Y_W      = 9;
    localparam int COLOUR_W = 24;

    // Packed colour is {R, G, B}, 8 bits each.
    localparam int R_LSB = 16;
    localparam int G_LSB = 8;
    localparam int B_LSB = 0;

    typedef struct packed {
        logic [X_W-1:0]      x;
        logic [Y_W-1:0]      y;
        logic [COLOUR_W-1:0] rgb;
    } pixel_t;

endpackage

// File: rtl/vga_pixel_write_arbiter_if.sv
// Bundle between the drawing engines and the framebuffer write port.
// The slave modport is the arbiter's view of the bundle.
interface vga_pixel_write_arbiter_if import vga_pkg::*; #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]          req;
    logic [NUM_REQ-1:0]          req_lock;
    logic [NUM_REQ*X_W-1:0]      req_x;
    logic [NUM_REQ*Y_W-1:0]      req_y;
    logic [NUM_REQ*COLOUR_W-1:0] req_rgb;
    logic [NUM_REQ-1:0]          gnt;
    logic                        fb_we;
    logic [X_W-1:0]              fb_x;
    logic [Y_W-1:0]              fb_y;
    logic [COLOUR_W-1:0]         fb_rgb;
    logic                        fb_ready;
    logic [15:0]                 drop_count;

    modport slave (
        input  req, req_lock, req_x, req_y, req_rgb, fb_ready,
        output gnt, fb_we, fb_x, fb_y, fb_rgb, drop_count
    );

    modport master (
        output req, req_lock, req_x, req_y, req_rgb, fb_ready,
        input  gnt, fb_we, fb_x, fb_y, fb_rgb, drop_count
    );

endinterface

// File: rtl/vga_rr_pick.sv
// Rotating priority encoder: first set request at or after ptr, wrapping.
module vga_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PTR_W-1:0]   idx,
    output logic               any
);

    int j;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(ptr) + k) % NUM_REQ;
            if (!any && req[j]) begin
                gnt[j] = 1'b1;
                idx    = PTR_W'(j);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_pixel_write_arbiter.sv
// Round-robin arbiter with burst lock and off-screen clipping that shares
// one framebuffer write port, behind a one-entry back-pressured output register.
module vga_pixel_write_arbiter import vga_pkg::*; #(
    parameter int NUM_REQ = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    vga_pixel_write_arbiter_if.slave  bus
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [X_W-1:0] H_MAX = X_W'(H_SIZE);
    localparam logic [Y_W-1:0] V_MAX = Y_W'(V_SIZE);

    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   owner;
    logic               lock_active;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] pick_gnt;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_any;
    logic               can_accept;
    logic               accept;
    logic               on_screen;
    pixel_t             sel_pix;
    pixel_t             out_q;
    logic               out_valid;
    logic [15:0]        drop_q;

    // A live lock narrows eligibility to the owner; once the owner lets go,
    // everyone competes again in the same cycle.
    always_comb begin
        eligible = bus.req;
        if (lock_active && bus.req[owner]) begin
            eligible        = '0;
            eligible[owner] = 1'b1;
        end
    end

    vga_rr_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_pick (
        .req (eligible),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        can_accept  = !out_valid || bus.fb_ready;
        accept      = !reset && can_accept && pick_any;
        sel_pix.x   = bus.req_x[pick_idx*X_W +: X_W];
        sel_pix.y   = bus.req_y[pick_idx*Y_W +: Y_W];
        sel_pix.rgb = bus.req_rgb[pick_idx*COLOUR_W +: COLOUR_W];
        on_screen   = (sel_pix.x < H_MAX) && (sel_pix.y < V_MAX);
    end

    assign bus.gnt        = accept ? pick_gnt : '0;
    assign bus.fb_we      = out_valid;
    assign bus.fb_x       = out_q.x;
    assign bus.fb_y       = out_q.y;
    assign bus.fb_rgb     = out_q.rgb;
    assign bus.drop_count = drop_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr         <= '0;
            owner       <= '0;
            lock_active <= 1'b0;
            out_valid   <= 1'b0;
            out_q       <= '0;
            drop_q      <= '0;
        end else begin
            if (accept) begin
                ptr         <= (pick_idx == PTR_W'(NUM_REQ - 1)) ? '0 : pick_idx + PTR_W'(1);
                owner       <= pick_idx;
                lock_active <= bus.req_lock[pick_idx];
            end else if (lock_active && !bus.req[owner]) begin
                lock_active <= 1'b0;
            end

            // A new on-screen pixel may replace the one retiring this cycle.
            if (accept && on_screen) begin
                out_q     <= sel_pix;
                out_valid <= 1'b1;
            end else if (out_valid && bus.fb_ready) begin
                out_valid <= 1'b0;
            end

            if (accept && !on_screen && drop_q != 16'hFFFF)
                drop_q <= drop_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_vga_pixel_write_arbiter.sv
// Directed bench for the pixel write arbiter; written pixels are checked
// against a scoreboard filled from the bench's own requester data.
module tb_vga_pixel_write_arbiter;

    logic clock;
    logic reset;

    vga_pixel_write_arbiter_if #(.NUM_REQ(4)) bus ();

    vga_pixel_write_arbiter #(.NUM_REQ(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int total = 0;
    int bad   = 0;

    logic [3:0]  req_v;
    logic [3:0]  lock_v;
    logic [9:0]  px_x   [4];
    logic [8:0]  px_y   [4];
    logic [23:0] px_rgb [4];
    logic [15:0] exp_drop;
    logic [42:0] sb [$];

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic drive_bus();
        bus.req      = req_v;
        bus.req_lock = lock_v;
        for (int i = 0; i < 4; i++) begin
            bus.req_x[i*10 +: 10]   = px_x[i];
            bus.req_y[i*9 +: 9]     = px_y[i];
            bus.req_rgb[i*24 +: 24] = px_rgb[i];
        end
    endtask

    // One clock: drive, check combinational grant and registered outputs
    // against the model, then advance the model and move to the next negedge.
    task automatic apply_stimulus(input logic [3:0] exp_gnt, input string tag);
        drive_bus();
        #1;
        check_output({tag, ":gnt"}, 64'(bus.gnt), 64'(exp_gnt));
        check_output({tag, ":fb_we"}, 64'(bus.fb_we), 64'(sb.size() != 0));
        check_output({tag, ":drop"}, 64'(bus.drop_count), 64'(exp_drop));
        if (sb.size() != 0) begin
            if (bus.fb_we)
                check_output({tag, ":fb_data"}, 64'({bus.fb_x, bus.fb_y, bus.fb_rgb}), 64'(sb[0]));
            if (bus.fb_ready)
                void'(sb.pop_front());
        end
        for (int i = 0; i < 4; i++) begin
            if (exp_gnt[i]) begin
                if (px_x[i] < 10'd640 && px_y[i] < 9'd480)
                    sb.push_back({px_x[i], px_y[i], px_rgb[i]});
                else if (exp_drop != 16'hFFFF)
                    exp_drop = exp_drop + 16'd1;
            end
        end
        @(negedge clock);
    endtask

    initial begin
        reset        = 1'b1;
        req_v        = 4'b1111;
        lock_v       = 4'b0000;
        exp_drop     = 16'd0;
        bus.fb_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            px_x[i]   = 10'(10 * i + 1);
            px_y[i]   = 9'(20 * i + 2);
            px_rgb[i] = 24'h111111 * 24'(i + 1);
        end
        drive_bus();
        @(negedge clock);

        // Reset held with all requests pending, then release.
        apply_stimulus(4'b0000, "reset0");
        apply_stimulus(4'b0000, "reset1");
        reset = 1'b0;
        apply_stimulus(4'b0001, "rr0");
        apply_stimulus(4'b0010, "rr1");
        apply_stimulus(4'b0100, "rr2");
        apply_stimulus(4'b1000, "rr3");
        apply_stimulus(4'b0001, "rr4");
        req_v = 4'b0000;
        apply_stimulus(4'b0000, "rr_drain0");
        apply_stimulus(4'b0000, "rr_drain1");

        // Back-pressure with a second pixel waiting.
        px_x[0] = 10'd5; px_y[0] = 9'd7; px_rgb[0] = 24'hFF0000;
        req_v = 4'b0001;
        apply_stimulus(4'b0001, "bp_load");
        px_x[0] = 10'd6; px_rgb[0] = 24'h00FF00;
        bus.fb_ready = 1'b0;
        apply_stimulus(4'b0000, "bp_stall0");
        apply_stimulus(4'b0000, "bp_stall1");
        apply_stimulus(4'b0000, "bp_stall2");
        bus.fb_ready = 1'b1;
        apply_stimulus(4'b0001, "bp_release");
        req_v = 4'b0000;
        apply_stimulus(4'b0000, "bp_drain0");
        apply_stimulus(4'b0000, "bp_drain1");

        // Burst lock on requester 1 while 0 and 2 also request.
        req_v = 4'b0111;
        lock_v = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            px_x[1] = 10'(100 + k);
            apply_stimulus(4'b0010, $sformatf("lock%0d", k));
        end
        lock_v = 4'b0000;
        px_x[1] = 10'd200;
        apply_stimulus(4'b0010, "lock_last");
        req_v = 4'b0101;
        apply_stimulus(4'b0100, "lock_after");
        req_v = 4'b0000;
        apply_stimulus(4'b0000, "lock_drain0");
        apply_stimulus(4'b0000, "lock_drain1");

        // Owner takes a lock then drops its request.
        req_v = 4'b0010;
        lock_v = 4'b0010;
        apply_stimulus(4'b0010, "own_lock");
        req_v = 4'b0001;
        lock_v = 4'b0000;
        apply_stimulus(4'b0001, "own_drop");
        req_v = 4'b0000;
        apply_stimulus(4'b0000, "own_drain0");
        apply_stimulus(4'b0000, "own_drain1");

        // Clipping at both edges, then the last on-screen corner.
        req_v = 4'b0001;
        px_x[0] = 10'd640; px_y[0] = 9'd0;
        apply_stimulus(4'b0001, "clip_x");
        px_x[0] = 10'd0; px_y[0] = 9'd480;
        apply_stimulus(4'b0001, "clip_y");
        req_v = 4'b0000;
        apply_stimulus(4'b0000, "clip_idle");
        req_v = 4'b0001;
        px_x[0] = 10'd639; px_y[0] = 9'd479; px_rgb[0] = 24'h123456;
        apply_stimulus(4'b0001, "corner");
        req_v = 4'b0000;
        apply_stimulus(4'b0000, "corner_drain0");
        apply_stimulus(4'b0000, "corner_drain1");

        // Saturate the drop counter.
        req_v = 4'b0001;
        px_x[0] = 10'd640; px_y[0] = 9'd0;
        drive_bus();
        repeat (65600) @(negedge clock);
        exp_drop = 16'hFFFF;
        req_v = 4'b0000;
        apply_stimulus(4'b0000, "drop_sat");

        // Reset while a write is stalled.
        req_v = 4'b0001;
        px_x[0] = 10'd1; px_y[0] = 9'd2; px_rgb[0] = 24'hABCDEF;
        bus.fb_ready = 1'b0;
        apply_stimulus(4'b0001, "mid_load");
        req_v = 4'b0000;
        apply_stimulus(4'b0000, "mid_stall");
        reset = 1'b1;
        apply_stimulus(4'b0000, "mid_reset");
        sb.delete();
        exp_drop = 16'd0;
        reset = 1'b0;
        bus.fb_ready = 1'b1;
        apply_stimulus(4'b0000, "mid_after");
        req_v = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            px_x[i] = 10'(i + 50);
            px_y[i] = 9'(i + 60);
        end
        apply_stimulus(4'b0001, "mid_ptr0");
        req_v = 4'b0000;
        apply_stimulus(4'b0000, "mid_drain0");
        apply_stimulus(4'b0000, "mid_drain1");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
